alu_driver: RTL
===============

ALU_DRIVER -- requirements
Module: alu_driver

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning command FIFO depth (power of two, at least 2).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have ports cmd_valid (input, 1) and cmd_ready (output, 1), forming the command handshake.
REQ-005 SHALL have ports cmd_a (input, 4), cmd_b (input, 4) and cmd_op (input, 3), carrying the command operands and opcode.
REQ-006 SHALL have ports alu_a (output, 4), alu_b (output, 4) and alu_opcode (output, 3), which drive the external combinational 4-bit ALU.
REQ-007 SHALL have ports alu_result (input, 8) and alu_carry (input, 1), the ALU outputs.
REQ-008 SHALL have ports rsp_valid (output, 1) and rsp_ready (input, 1), forming the response handshake.
REQ-009 SHALL have ports rsp_result (output, 8), rsp_carry (output, 1), rsp_op (output, 3, the opcode echo) and rsp_err (output, 1).
REQ-010 SHALL have port level, output, $clog2(DEPTH)+1 bits, giving the FIFO occupancy.

Function
REQ-011 SHALL write a command into the FIFO on a rising edge with cmd_valid && cmd_ready; cmd_ready = (level != DEPTH).
REQ-012 SHALL NOT accept a command while full, even when a pop occurs in the same cycle.
REQ-013 SHALL implement FSM states IDLE, ISSUE and RESP.
REQ-014 IDLE with level>0 SHALL pop the FIFO head into the operand registers and go to ISSUE; IDLE with an empty FIFO stays in IDLE.
REQ-015 ISSUE SHALL, at the next edge, capture alu_result, alu_carry and the opcode into the rsp_* registers, set rsp_valid=1 and go to RESP.
REQ-016 RESP SHALL hold all rsp_* stable until rsp_valid && rsp_ready; at that edge rsp_valid clears, then:
- pop and go to ISSUE if level>0;
- otherwise go to IDLE.
REQ-017 alu_a, alu_b and alu_opcode SHALL come directly from the operand registers and change only on a pop.
REQ-018 Latency SHALL be:
- rsp_valid rises on the 2nd edge after the accepting edge, when the FIFO is empty and the FSM is in IDLE;
- sustained throughput is one response per 2 cycles with rsp_ready=1.
REQ-019 Responses SHALL return in command order, with no drop or duplication.
REQ-020 A simultaneous push and pop SHALL leave level unchanged; FIFO pointers SHALL wrap modulo DEPTH.
REQ-021 rsp_err SHALL be 0 except as defined in REQ-026.

Reset
REQ-022 rst high SHALL immediately set the FSM to IDLE and level=0, and empty the FIFO (queued commands are discarded).
REQ-023 rst high SHALL immediately set rsp_valid=0, rsp_result=0, rsp_carry=0, rsp_op=0, rsp_err=0, alu_a=0, alu_b=0 and alu_opcode=0.
REQ-024 After reset is released, cmd_ready SHALL be 1.
REQ-025 A reset asserted mid-ISSUE or mid-RESP SHALL discard the in-flight command, with no response produced.

Configuration
REQ-026 With macro ALU_DRIVER_DIVZERO_EN defined, a popped command with opcode 3'b011 and b==0 SHALL be handled as follows:
- ISSUE captures rsp_result=8'hFF, rsp_carry=0 and rsp_err=1, ignoring the ALU inputs;
- timing is identical to REQ-015.
REQ-027 Without the macro, division by zero SHALL be captured from the ALU like any other opcode, and rsp_err SHALL be tied to 0.

Verification
REQ-028 Single ADD: cmd a=9, b=8, op=000; ALU model returns 0x01 with carry=1 -> rsp_result=0x01, rsp_carry=1, rsp_op=000, rsp_valid on the 2nd edge after acceptance.
REQ-029 Backpressure fill, DEPTH=4, rsp_ready=0: cmd_valid held high -> 5 commands accepted (1 in RESP, 4 queued), then cmd_ready=0 and level=4; rsp_* stable; releasing rsp_ready returns all 5 responses in order.
REQ-030 Streaming with rsp_ready=1: 8 back-to-back commands -> responses every 2 cycles and level never exceeds 4.
REQ-031 Reset mid-RESP with 3 commands queued -> rsp_valid=0, level=0, no further responses, cmd_ready=1 after release.
REQ-032 ALU_DRIVER_DIVZERO_EN defined: a=7, b=0, op=011 -> rsp_result=0xFF, rsp_err=1; undefined: rsp_result equals the ALU output and rsp_err=0.

Source files
------------

// File: rtl/alu_driver.sv
// rtl/alu_driver.sv - command FIFO and IDLE/ISSUE/RESP sequencer driving an external 4-bit ALU
// Optional: define ALU_DRIVER_DIVZERO_EN to flag divide-by-zero (op 3'b011, b==0) with rsp_err.
module alu_driver #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [3:0]               cmd_a,
  input  logic [3:0]               cmd_b,
  input  logic [2:0]               cmd_op,
  output logic [3:0]               alu_a,
  output logic [3:0]               alu_b,
  output logic [2:0]               alu_opcode,
  input  logic [7:0]               alu_result,
  input  logic                     alu_carry,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [7:0]               rsp_result,
  output logic                     rsp_carry,
  output logic [2:0]               rsp_op,
  output logic                     rsp_err,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t          state;
  logic [10:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [10:0]     head;
  logic            push;
  logic            pop;

  // Full is judged on the registered level, so a same-cycle pop never frees a slot early.
  assign cmd_ready = (level != LW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rd_ptr];

  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = (level != '0);
      RESP:    pop = rsp_ready && (level != '0);
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b};
  end

`ifdef ALU_DRIVER_DIVZERO_EN
  logic div_zero;
  logic rsp_err_q;
  assign div_zero = (alu_opcode == 3'b011) && (alu_b == 4'd0);
  assign rsp_err  = rsp_err_q;
`else
  assign rsp_err  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      level      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_op     <= '0;
`ifdef ALU_DRIVER_DIVZERO_EN
      rsp_err_q  <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr                       <= rd_ptr + 1'b1;
        {alu_opcode, alu_a, alu_b}   <= head;
      end
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;

      case (state)
        IDLE: begin
          if (pop) state <= ISSUE;
        end
        ISSUE: begin
          rsp_valid  <= 1'b1;
          rsp_op     <= alu_opcode;
          rsp_result <= alu_result;
          rsp_carry  <= alu_carry;
`ifdef ALU_DRIVER_DIVZERO_EN
          rsp_err_q  <= 1'b0;
          if (div_zero) begin
            rsp_result <= 8'hFF;
            rsp_carry  <= 1'b0;
            rsp_err_q  <= 1'b1;
          end
`endif
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= pop ? ISSUE : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
